max_scan_ctrl: RTL and testbench
================================

// Module: max_scan_ctrl
// PURPOSE
//  Sequences the 4-bit max-comparator datapath over a burst of samples and reports the running maximum and its position.
//  Accepts up to MAX_LEN unsigned values through a valid/ready handshake and compares each one against the stored maximum.
//  Pulses done with the final max value and its index.
//  Sits between the sample source (switch/counter logic) and the display/LED stage.
// PARAMETERS
//  WIDTH    4   sample width, unsigned
//  MAX_LEN  16  maximum samples per scan
//  LEN_W    4   width of len/index fields; 2**LEN_W == MAX_LEN
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      begin a scan; sampled only in IDLE
//  len        in   LEN_W  samples in scan; 0 means MAX_LEN; captured when start is accepted
//  abort      in   1      cancel the scan in progress
//  in_valid   in   1      sample available
//  in_data    in   WIDTH  sample value
//  in_ready   out  1      block can accept a sample (high only in SCAN)
//  busy       out  1      high in SCAN
//  done       out  1      one-cycle pulse when the result is final
//  max_value  out  WIDTH  largest sample of the last completed scan
//  max_index  out  LEN_W  index (0-based) of that sample
// BEHAVIOUR
//  Reset: synchronous, active-high on clk; state=IDLE.
//   in_ready, busy, done, max_value, max_index and the sample counter cnt all reset to 0.
//  FSM: IDLE -> SCAN on start; SCAN -> DONE on last accepted sample; SCAN -> IDLE on abort; DONE -> IDLE unconditionally.
//  IDLE: in_ready=0. On start, capture len (0 -> MAX_LEN), set cnt=0 and enter SCAN.
//  SCAN: in_ready=1, busy=1. A sample is accepted when in_valid && in_ready.
//   First sample (cnt==0): load the running max and index with in_data and 0.
//   Later samples: update only if in_data > running max (strict), so on a tie the earliest index wins.
//   Each acceptance increments cnt. When cnt == len-1 on acceptance, go to DONE.
//  DONE (one cycle): done=1, busy=0; max_value/max_index publish the running max and index.
//   Latency: done asserts exactly 1 cycle after the last sample is accepted.
//  Outputs hold their published value until the next DONE or reset; partial scans never reach the outputs.
//  Boundary cases:
//   - start while busy or in DONE is ignored.
//   - abort in SCAN beats a same-cycle sample: the sample is not accepted, go to IDLE, no done.
//   - abort outside SCAN has no effect.
//   - len=1: a single sample gives DONE with index 0.
//   - len=0 scans 16 samples; cnt never wraps within a scan.
//   - in_valid low stalls the scan indefinitely; there is no timeout.
//   - reset mid-scan discards all progress and clears the outputs.
// CONFIGURATION
//  MAX_SCAN_MIN_EN defined: adds outputs min_value[WIDTH] and min_index[LEN_W] (reset 0).
//   The running min is tracked in parallel: update only if in_data < running min (strict, earliest index wins on tie).
//   It is published in the same DONE cycle as the max.
//  Not defined: the ports are absent and there is no min logic; max behaviour is identical either way.
// TESTING
//  1. reset; start len=4; samples 3,9,2,7 back-to-back -> done 1 cycle after 4th accept; max_value=9, max_index=1.
//  2. len=3, samples 5,5,5 with in_valid gaps of 2 cycles -> max_value=5, max_index=0 (tie keeps earliest); done only once.
//  3. len=0, samples 0..15 ascending -> exactly 16 accepts; max_value=15, max_index=15.
//  4. len=4, abort after 2 samples -> IDLE, no done, outputs keep prior result.
//     Also: start during SCAN is ignored; start in DONE is ignored.
//  5. reset asserted mid-scan -> next cycle all outputs 0, in_ready=0; a new start/len=1 with sample 6 -> max_value=6, max_index=0.
//  6. MAX_SCAN_MIN_EN, len=5, samples 8,2,F,2,A -> max F/index 2, min 2/index 1.

Source files
------------

// File: rtl/max_scan_ctrl.sv
// ==========================================================================
// max_scan_ctrl : scans a valid/ready sample burst for its maximum and index.
// Define MAX_SCAN_MIN_EN to add running min/index outputs.   Rev 1.0
// ==========================================================================
`default_nettype none

module max_scan_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] max_value_o,
  output logic [LEN_W-1:0] max_index_o
`ifdef MAX_SCAN_MIN_EN
  ,
  output logic [WIDTH-1:0] min_value_o,
  output logic [LEN_W-1:0] min_index_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] last_q, last_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [LEN_W-1:0] run_idx_q, run_idx_d;
  logic [WIDTH-1:0] max_value_q, max_value_d;
  logic [LEN_W-1:0] max_index_q, max_index_d;

  logic accept;
  logic last_accept;

  // Abort outranks a same-cycle sample, so it is folded into acceptance.
  assign accept      = (state_q == S_SCAN) && in_valid_i && !abort_i;
  assign last_accept = accept && (cnt_q == last_q);

  assign in_ready_o  = (state_q == S_SCAN);
  assign busy_o      = (state_q == S_SCAN);
  assign done_o      = (state_q == S_DONE);
  assign max_value_o = max_value_q;
  assign max_index_o = max_index_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_value_d = max_value_q;
    max_index_d = max_index_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // Store the index of the final sample; len 0 selects a full scan.
          last_d  = (len_i == '0) ? LEN_W'(MAX_LEN - 1) : len_i - 1'b1;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if ((cnt_q == '0) || (in_data_i > run_max_q)) begin
            run_max_d = in_data_i;
            run_idx_d = cnt_q;
          end
          if (last_accept) begin
            max_value_d = run_max_d;
            max_index_d = run_idx_d;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_value_q <= '0;
      max_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_value_q <= max_value_d;
      max_index_q <= max_index_d;
    end
  end

`ifdef MAX_SCAN_MIN_EN
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [LEN_W-1:0] run_midx_q, run_midx_d;
  logic [WIDTH-1:0] min_value_q, min_value_d;
  logic [LEN_W-1:0] min_index_q, min_index_d;

  assign min_value_o = min_value_q;
  assign min_index_o = min_index_q;

  always_comb begin
    run_min_d   = run_min_q;
    run_midx_d  = run_midx_q;
    min_value_d = min_value_q;
    min_index_d = min_index_q;
    if (accept && ((cnt_q == '0) || (in_data_i < run_min_q))) begin
      run_min_d  = in_data_i;
      run_midx_d = cnt_q;
    end
    if (last_accept) begin
      min_value_d = run_min_d;
      min_index_d = run_midx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_min_q   <= '0;
      run_midx_q  <= '0;
      min_value_q <= '0;
      min_index_q <= '0;
    end else begin
      run_min_q   <= run_min_d;
      run_midx_q  <= run_midx_d;
      min_value_q <= min_value_d;
      min_index_q <= min_index_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_max_scan_ctrl.sv
// ==========================================================================
// tb_max_scan_ctrl : directed self-checking bench for max_scan_ctrl.
// Define MAX_SCAN_MIN_EN to also exercise the min outputs.   Rev 1.0
// ==========================================================================
`default_nettype none

module tb_max_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [3:0] len_i;
  logic       abort_i;
  logic       in_valid_i;
  logic [3:0] in_data_i;
  logic       in_ready_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] max_value_o;
  logic [3:0] max_index_o;
`ifdef MAX_SCAN_MIN_EN
  logic [3:0] min_value_o;
  logic [3:0] min_index_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  max_scan_ctrl #(.WIDTH(4), .MAX_LEN(16), .LEN_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .max_value_o (max_value_o),
    .max_index_o (max_index_o)
`ifdef MAX_SCAN_MIN_EN
    ,
    .min_value_o (min_value_o),
    .min_index_o (min_index_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] l);
    start_i = 1'b1;
    len_i   = l;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_busy", busy_o, 1);
  endtask

  // Presents one sample for exactly one clock; valid is left high for the caller.
  task automatic send(input logic [3:0] d);
    in_valid_i = 1'b1;
    in_data_i  = d;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_i = 1'b0; len_i = 4'd0; abort_i = 1'b0;
    in_valid_i = 1'b0; in_data_i = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready_o, 0);
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_max",   max_value_o, 0);
    chk("rst_idx",   max_index_o, 0);
`ifdef MAX_SCAN_MIN_EN
    chk("rst_min",   min_value_o, 0);
    chk("rst_midx",  min_index_o, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // 1: len 4, back-to-back 3,9,2,7
    do_start(4'd4);
    chk("t1_ready", in_ready_o, 1);
    send(4'd3); send(4'd9); send(4'd2);
    chk("t1_nodone_early", done_o, 0);
    send(4'd7);
    chk("t1_done", done_o, 1);
    chk("t1_busy_in_done", busy_o, 0);
    chk("t1_max", max_value_o, 9);
    chk("t1_idx", max_index_o, 1);
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_done_pulse", done_o, 0);
    chk("t1_idle_ready", in_ready_o, 0);
    chk("t1_hold_max", max_value_o, 9);

    // 2: len 3, equal samples with 2-cycle valid gaps
    do_start(4'd3);
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("t2_stall_busy", busy_o, 1);
      chk("t2_stall_nodone", done_o, 0);
      send(4'd5);
    end
    in_valid_i = 1'b0;
    chk("t2_done", done_o, 1);
    chk("t2_max", max_value_o, 5);
    chk("t2_idx", max_index_o, 0);
    @(negedge clk);
    chk("t2_single_done", done_o, 0);

    // 3: len 0 means 16 samples, ascending
    do_start(4'd0);
    for (int i = 0; i < 15; i++) send(4'(i));
    chk("t3_busy_after15", busy_o, 1);
    chk("t3_nodone_after15", done_o, 0);
    send(4'd15);
    in_valid_i = 1'b0;
    chk("t3_done", done_o, 1);
    chk("t3_max", max_value_o, 15);
    chk("t3_idx", max_index_o, 15);
    @(negedge clk);

    // 4: start during SCAN ignored, abort beats a sample, outputs held
    do_start(4'd4);
    send(4'd1); send(4'd2);
    in_valid_i = 1'b0;
    start_i = 1'b1; len_i = 4'd1;
    @(negedge clk);
    start_i = 1'b0;
    chk("t4_start_in_scan_busy", busy_o, 1);
    abort_i = 1'b1; in_valid_i = 1'b1; in_data_i = 4'hF;
    @(negedge clk);
    abort_i = 1'b0; in_valid_i = 1'b0;
    chk("t4_abort_idle", busy_o, 0);
    chk("t4_abort_nodone", done_o, 0);
    chk("t4_abort_hold_max", max_value_o, 15);
    chk("t4_abort_hold_idx", max_index_o, 15);
    @(negedge clk);
    chk("t4_abort_still_nodone", done_o, 0);
    // abort in IDLE has no effect on a following scan
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    // len 1 scan, then start asserted during DONE must be ignored
    do_start(4'd1);
    send(4'd4);
    in_valid_i = 1'b0;
    chk("t4_len1_done", done_o, 1);
    chk("t4_len1_max", max_value_o, 4);
    chk("t4_len1_idx", max_index_o, 0);
    start_i = 1'b1; len_i = 4'd2;
    @(negedge clk);
    start_i = 1'b0;
    chk("t4_start_in_done_ignored", busy_o, 0);
    @(negedge clk);

    // 5: reset mid-scan clears everything, then a fresh len 1 scan
    do_start(4'd4);
    send(4'd1); send(4'd2);
    in_valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_rst_ready", in_ready_o, 0);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_done", done_o, 0);
    chk("t5_rst_max", max_value_o, 0);
    chk("t5_rst_idx", max_index_o, 0);
    do_start(4'd1);
    send(4'd6);
    in_valid_i = 1'b0;
    chk("t5_done", done_o, 1);
    chk("t5_max", max_value_o, 6);
    chk("t5_idx", max_index_o, 0);
    @(negedge clk);

    // 6: max/min tracked together (min checked only when the feature is built)
    do_start(4'd5);
    send(4'd8); send(4'd2); send(4'hF); send(4'd2); send(4'hA);
    in_valid_i = 1'b0;
    chk("t6_done", done_o, 1);
    chk("t6_max", max_value_o, 15);
    chk("t6_idx", max_index_o, 2);
`ifdef MAX_SCAN_MIN_EN
    chk("t6_min", min_value_o, 2);
    chk("t6_midx", min_index_o, 1);
`endif
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
